// File: rtl/mux4way16.sv
// ---------------------------------------------------------------------------
// mux4way16
//
// Four-input word selector for the Hack-style datapath. A 2-bit select picks
// one of four WIDTH-bit words onto a purely combinational output, and a
// registered copy of the same word is provided one clock later for pipelined
// consumers.
//
// Ports
//   clk     in   1      system clock, state updates on the rising edge
//   rst     in   1      synchronous, active-high reset (clears out_q only)
//   a       in   WIDTH  word selected when select = 2'b00
//   b       in   WIDTH  word selected when select = 2'b01
//   c       in   WIDTH  word selected when select = 2'b10
//   d       in   WIDTH  word selected when select = 2'b11
//   select  in   2      word select
//   out     out  WIDTH  combinational selected word, independent of clk/rst
//   out_q   out  WIDTH  registered selected word, one cycle behind out
// ---------------------------------------------------------------------------
module mux4way16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [1:0]       select,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q
);

    logic [WIDTH-1:0] out_d;

    // All four codes are legal. The leading X assignment only matters when
    // select itself is X/Z in simulation; synthesis treats it as don't-care.
    always_comb begin
        out_d = {WIDTH{1'bx}};
        case (select)
            2'b00: out_d = a;
            2'b01: out_d = b;
            2'b10: out_d = c;
            2'b11: out_d = d;
            default: out_d = {WIDTH{1'bx}};
        endcase
    end

    assign out = out_d;

    // Reset has priority over the data path; out itself is never gated by rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

endmodule

// File: tb/tb_mux4way16.sv
// ---------------------------------------------------------------------------
// tb_mux4way16
//
// Self-checking bench for mux4way16: directed combinational checks, reset,
// latency, mid-stream reset, bit independence and a randomised stream. The
// registered path is scored through an expected queue filled when the
// stimulus is applied and drained after each clock edge.
// ---------------------------------------------------------------------------
module tb_mux4way16;

    localparam int WIDTH = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [WIDTH-1:0] a, b, c, d;
    logic [1:0]       select;
    logic [WIDTH-1:0] out, out_q;

    mux4way16 #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .a      (a),
        .b      (b),
        .c      (c),
        .d      (d),
        .select (select),
        .out    (out),
        .out_q  (out_q)
    );

    // ---------------- scoreboard ----------------
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] last_exp;
    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [WIDTH-1:0] got,
                            input logic [WIDTH-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: index a table of the four words by select.
    function automatic logic [WIDTH-1:0] model_sel();
        logic [WIDTH-1:0] w[4];
        w[0] = a;
        w[1] = b;
        w[2] = c;
        w[3] = d;
        return w[select];
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_words(input logic [WIDTH-1:0] wa, input logic [WIDTH-1:0] wb,
                             input logic [WIDTH-1:0] wc, input logic [WIDTH-1:0] wd);
        a = wa;
        b = wb;
        c = wc;
        d = wd;
    endtask

    // Change select and check the combinational output one time unit later.
    task automatic set_sel(input logic [1:0] s, input string tag);
        select = s;
        #1;
        check_eq(tag, out, model_sel());
    endtask

    // Push the expected registered value, take one rising edge, then compare.
    task automatic clock_step(input string tag);
        logic [WIDTH-1:0] e;
        @(negedge clk);
        exp_q.push_back(rst ? '0 : model_sel());
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL %s: scoreboard queue empty", tag);
        end else begin
            e = exp_q.pop_front();
            last_exp = e;
            check_eq(tag, out_q, e);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        set_words(16'h5555, 16'hAAAA, 16'h00FF, 16'hFF00);
        select = 2'b00;

        // Combinational sweep, no clock edge needed.
        set_sel(2'b00, "comb_sel00");
        check_eq("comb_sel00_val", out, 16'h5555);
        set_sel(2'b01, "comb_sel01");
        check_eq("comb_sel01_val", out, 16'hAAAA);
        set_sel(2'b10, "comb_sel10");
        check_eq("comb_sel10_val", out, 16'h00FF);
        set_sel(2'b11, "comb_sel11");
        check_eq("comb_sel11_val", out, 16'hFF00);

        // Data tracking on select = 10.
        @(negedge clk);
        select = 2'b10;
        c = 16'h1234;
        #1;
        check_eq("track_c", out, 16'h1234);
        a = 16'hDEAD;
        b = 16'hBEEF;
        d = 16'hCAFE;
        #1;
        check_eq("track_others", out, 16'h1234);

        // Reset for two edges with select = 11, d = FF00; out stays live.
        set_words(16'h5555, 16'hAAAA, 16'h00FF, 16'hFF00);
        select = 2'b11;
        rst = 1'b1;
        clock_step("rst_edge1");
        check_eq("rst_out_live1", out, 16'hFF00);
        clock_step("rst_edge2");
        check_eq("rst_out_live2", out, 16'hFF00);
        check_eq("rst_out_q_zero", out_q, 16'h0000);
        rst = 1'b0;
        clock_step("rst_release");
        check_eq("rst_release_val", out_q, 16'hFF00);

        // Hold between edges: input changes must not move out_q.
        a = 16'h0F0F;
        select = 2'b00;
        #1;
        check_eq("hold_out_q", out_q, last_exp);
        check_eq("hold_out", out, 16'h0F0F);
        a = 16'h5555;

        // Registered latency, stepping the select each cycle.
        for (int i = 0; i < 4; i++) begin
            select = i[1:0];
            clock_step("latency");
        end
        check_eq("latency_last", out_q, 16'hFF00);

        // Mid-stream reset for a single edge, then resume.
        select = 2'b00;
        clock_step("mid_pre");
        select = 2'b01;
        rst = 1'b1;
        clock_step("mid_rst");
        check_eq("mid_rst_zero", out_q, 16'h0000);
        rst = 1'b0;
        select = 2'b10;
        clock_step("mid_resume");
        check_eq("mid_resume_val", out_q, 16'h00FF);

        // Bit independence with single-bit words.
        set_words(16'h0001, 16'h0002, 16'h4000, 16'h8000);
        for (int i = 0; i < 4; i++) begin
            set_sel(i[1:0], "bit_comb");
            clock_step("bit_reg");
        end

        // Randomised stream with occasional reset.
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            set_words(WIDTH'($urandom_range(0, 16'hFFFF)), WIDTH'($urandom_range(0, 16'hFFFF)),
                      WIDTH'($urandom_range(0, 16'hFFFF)), WIDTH'($urandom_range(0, 16'hFFFF)));
            rst = ($urandom_range(0, 9) == 0);
            set_sel(2'($urandom_range(0, 3)), "rand_comb");
            clock_step("rand_reg");
        end
        rst = 1'b0;

        if (exp_q.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        // ---------------- final report ----------------
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Bound the whole run.
    initial begin
        #100000;
        $display("FAIL timeout: run exceeded time budget");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mux4way16.md
Name: mux4way16

Overview:
- 4-input, 16-bit-wide word selector for the Hack-style datapath.
- A 2-bit select picks one of four data words, a, b, c or d, onto a combinational output.
- A registered copy of the selected word is also provided for pipelined consumers.
- Leaf block with no internal state other than the output register.

Parameters:
- WIDTH, 16, bit width of each data input and of both outputs.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst  input  1  reset, synchronous and active-high; sampled on the rising edge of clk.
- a  input  WIDTH  data word selected when select = 2'b00.
- b  input  WIDTH  data word selected when select = 2'b01.
- c  input  WIDTH  data word selected when select = 2'b10.
- d  input  WIDTH  data word selected when select = 2'b11.
- select  input  2  word select.
- out  output  WIDTH  combinational selected word.
- out_q  output  WIDTH  registered selected word, one clk cycle behind out.

Behaviour:
- out, purely combinational with zero cycles of latency:
  - select 00 -> out = a.
  - select 01 -> out = b.
  - select 10 -> out = c.
  - select 11 -> out = d.
- out follows any change on a/b/c/d/select within the same delta/time step; no clock involvement.
- out does not depend on rst or clk; it is valid even while rst is asserted.
- Selection is bit-exact: every bit of out equals the same bit of the chosen input; no masking, extension or inversion.
- Select encoding is full; all four codes are legal and there is no default/invalid case.
  - If select contains X/Z in simulation, out is X. No X-pessimism workaround is required.
- out_q, registered:
  - Each rising clk edge with rst = 0: out_q <= current out value (the word selected by the current select).
  - Each rising clk edge with rst = 1: out_q <= all zeros. Reset has priority over the data path.
  - Latency select/data -> out_q is exactly 1 cycle.
  - Between edges out_q holds its value regardless of input changes.
  - Reset value of out_q: 16'h0000 (all WIDTH bits zero).
  - Before the first reset edge out_q is undefined (X in simulation).
- rst asserted mid-stream: out_q is zero on the edge where rst is sampled high. On the first edge after rst deasserts, out_q captures the then-current out.
- Simultaneous select change and clock edge: out_q captures the value selected by select as sampled at that edge (standard flop setup semantics).
- WIDTH scales all data ports and outputs uniformly. select stays 2 bits for every WIDTH.

Test Plan:
- Combinational sweep: a=5555, b=AAAA, c=00FF, d=FF00 (hex). select 00/01/10/11 -> out = 5555/AAAA/00FF/FF00 one time unit after each select change, no clock edge needed.
- Data tracking: select=10, change c from 00FF to 1234 -> out becomes 1234 immediately. Changing a, b or d leaves out unchanged.
- Reset: rst=1 for two clk edges with select=11, d=FF00 -> out_q=0000 while out=FF00. Deassert rst -> out_q=FF00 after the next edge.
- Registered latency: rst=0, on consecutive cycles step select 00->01->10->11 -> out_q shows 5555, AAAA, 00FF, FF00, each one cycle after the corresponding select.
- Mid-stream reset: while streaming as above, assert rst for one edge -> out_q=0000 for that cycle, then resumes with the currently selected word on the next edge.
- Bit independence: a=0001, b=0002, c=4000, d=8000 with each select -> only the expected single bit set on out and, one cycle later, on out_q.
